// File: rtl/pgm_sched.sv
// Packet-generation scheduler: paces pgm_rd start pulses by packet count and inter-packet gap,
// honouring downstream almost-full and a graceful stop request.
module pgm_sched #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [CNT_W-1:0] cfg_pkt_num,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             in_eop,
  input  logic             in_alf,
  output logic             out_start_flag,
  output logic             out_finish_flag,
  output logic             out_busy,
  output logic             out_done,
  output logic [CNT_W-1:0] out_pkt_cnt
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitEop, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pkt_num_q, pkt_num_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             finish_q, finish_d;
  logic             stop_q, stop_d;
  logic             stop_pend;
  logic             start_pulse;

  // A stop pulse acts in the same cycle it arrives, not only once it is latched.
  assign stop_pend = stop_q | cfg_stop;

  always_comb begin
    state_d     = state_q;
    pkt_num_d   = pkt_num_q;
    gap_d       = gap_q;
    issued_d    = issued_q;
    pkt_cnt_d   = pkt_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    finish_d    = finish_q;
    stop_d      = stop_q;
    start_pulse = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (cfg_start && !cfg_stop) begin
          state_d   = StIssue;
          pkt_num_d = cfg_pkt_num;
          gap_d     = cfg_gap;
          issued_d  = '0;
          pkt_cnt_d = '0;
          finish_d  = 1'b0;
          stop_d    = 1'b0;
        end
      end

      StIssue: begin
        if (stop_pend) begin
          state_d  = StDone;
          finish_d = 1'b1;
          stop_d   = 1'b0;
        end else if (!in_alf) begin
          start_pulse = 1'b1;
          issued_d    = issued_q + CNT_W'(1);
          if ((pkt_num_q != '0) && (issued_d == pkt_num_q)) begin
            finish_d = 1'b1;
          end
          state_d = StWaitEop;
        end
      end

      StWaitEop: begin
        if (cfg_stop) begin
          stop_d = 1'b1;
        end
        // Let the in-flight packet finish whole, but mark it as the last one.
        if (stop_pend) begin
          finish_d = 1'b1;
        end
        if (in_eop) begin
          if (pkt_cnt_q != '1) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          end
          if (finish_q || stop_pend) begin
            state_d  = StDone;
            finish_d = 1'b1;
            stop_d   = 1'b0;
          end else if (gap_q == '0) begin
            state_d = StIssue;
          end else begin
            state_d   = StGap;
            gap_cnt_d = gap_q;
          end
        end
      end

      StGap: begin
        if (stop_pend) begin
          state_d  = StDone;
          finish_d = 1'b1;
          stop_d   = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_d = StIssue;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pkt_num_q <= '0;
      gap_q     <= '0;
      issued_q  <= '0;
      pkt_cnt_q <= '0;
      gap_cnt_q <= '0;
      finish_q  <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_num_q <= pkt_num_d;
      gap_q     <= gap_d;
      issued_q  <= issued_d;
      pkt_cnt_q <= pkt_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      finish_q  <= finish_d;
      stop_q    <= stop_d;
    end
  end

  assign out_start_flag  = start_pulse;
  assign out_finish_flag = finish_q;
  assign out_busy        = (state_q != StIdle) && (state_q != StDone);
  assign out_done        = (state_q == StDone);
  assign out_pkt_cnt     = pkt_cnt_q;

endmodule
